// File: rtl/alu_control.sv
// Registered ALU-control decoder: maps the main-control operation class and
// the instruction function field onto the 3-bit ALU select plus an illegal flag.
module alu_control (
    input  logic       inp_clk,
    input  logic       inp_rst_n,
    input  logic [1:0] inp_aluOp,
    input  logic [3:0] inp_func,
    output logic [2:0] out_aluControl,
    output logic       out_illegal
);

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b011;
    localparam logic [2:0] SEL_SLT = 3'b100;
    localparam logic [2:0] SEL_XOR = 3'b101;
    localparam logic [2:0] SEL_NOR = 3'b110;
    localparam logic [2:0] SEL_SLL = 3'b111;

    logic [2:0] w_sel;
    logic       w_illegal;
    logic [2:0] r_sel;
    logic       r_illegal;

    // Unknown or unlisted codes fall into the defaults: ADD, not illegal.
    always_comb begin
        w_sel     = SEL_ADD;
        w_illegal = 1'b0;
        case (inp_aluOp)
            2'b00: begin
                case (inp_func)
                    4'd0:  w_sel = SEL_ADD;
                    4'd1:  w_sel = SEL_SUB;
                    4'd2:  w_sel = SEL_AND;
                    4'd3:  w_sel = SEL_OR;
                    4'd4:  w_sel = SEL_SLT;
                    4'd5:  w_sel = SEL_XOR;
                    4'd6:  w_sel = SEL_NOR;
                    4'd7:  w_sel = SEL_SLL;
                    4'd8, 4'd9, 4'd10, 4'd11,
                    4'd12, 4'd13, 4'd14, 4'd15: begin
                        w_sel     = SEL_ADD;
                        w_illegal = 1'b1;
                    end
                    default: begin
                        w_sel     = SEL_ADD;
                        w_illegal = 1'b0;
                    end
                endcase
            end
            2'b01: w_sel = SEL_ADD;
            2'b10: w_sel = SEL_SUB;
            2'b11: begin
                case (inp_func[1:0])
                    2'b00:   w_sel = SEL_AND;
                    2'b01:   w_sel = SEL_OR;
                    2'b10:   w_sel = SEL_SLT;
                    2'b11:   w_sel = SEL_XOR;
                    default: w_sel = SEL_ADD;
                endcase
            end
            default: begin
                w_sel     = SEL_ADD;
                w_illegal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge inp_clk) begin
        if (!inp_rst_n) begin
            r_sel     <= SEL_ADD;
            r_illegal <= 1'b0;
        end else begin
            r_sel     <= w_sel;
            r_illegal <= w_illegal;
        end
    end

    assign out_aluControl = r_sel;
    assign out_illegal    = r_illegal;

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: expectations are queued when inputs are
// driven and popped one cycle later when the registered outputs appear.
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] aluop;
    logic [3:0] func;
    logic [2:0] ctl;
    logic       ill;

    logic [2:0] q_ctl[$];
    logic       q_ill[$];
    int total = 0;
    int bad   = 0;

    alu_control dut (
        .inp_clk        (clk),
        .inp_rst_n      (rst_n),
        .inp_aluOp      (aluop),
        .inp_func       (func),
        .out_aluControl (ctl),
        .out_illegal    (ill)
    );

    always #5 clk = ~clk;

    // Reference decode built directly from the select tables.
    function automatic logic [3:0] model(input logic [1:0] op, input logic [3:0] f);
        logic [2:0] rtype [8];
        logic [2:0] imm [4];
        rtype = '{3'b010, 3'b011, 3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        imm   = '{3'b000, 3'b001, 3'b100, 3'b101};
        case (op)
            2'b00:   return f[3] ? 4'b1010 : {1'b0, rtype[f[2:0]]};
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0011;
            default: return {1'b0, imm[f[1:0]]};
        endcase
    endfunction

    // Drive one input pair mid-cycle, queue its expectation, sample after the edge.
    task automatic apply(input logic r, input logic [1:0] op, input logic [3:0] f);
        logic [3:0] e;
        @(negedge clk);
        rst_n = r;
        aluop = op;
        func  = f;
        e = r ? model(op, f) : 4'b0010;
        q_ctl.push_back(e[2:0]);
        q_ill.push_back(e[3]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] ec;
        logic       ei;
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 2'b00, 4'd1);
            ec = q_ctl.pop_front();
            ei = q_ill.pop_front();
            total++;
            if (ctl !== 3'b010 || ill !== 1'b0 || ec !== 3'b010) begin
                bad++;
                $display("FAIL reset%0d: got ctl=%b ill=%b want ctl=010 ill=0", k, ctl, ill);
            end
        end
        apply(1'b1, 2'b00, 4'd1);
        ec = q_ctl.pop_front();
        ei = q_ill.pop_front();
        total++;
        if (ctl !== 3'b011 || ill !== ei) begin
            bad++;
            $display("FAIL reset_release: got ctl=%b ill=%b want ctl=011 ill=%b", ctl, ill, ei);
        end
    endtask

    task automatic test_rtype();
        logic [2:0] ec;
        logic       ei;
        for (int f = 0; f < 8; f++) begin
            apply(1'b1, 2'b00, 4'(f));
            ec = q_ctl.pop_front();
            ei = q_ill.pop_front();
            total++;
            if (ctl !== ec || ill !== ei) begin
                bad++;
                $display("FAIL rtype_f%0d: got ctl=%b ill=%b want ctl=%b ill=%b", f, ctl, ill, ec, ei);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] fs [2];
        logic [2:0] ec;
        logic       ei;
        fs = '{4'd8, 4'd15};
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 2'b00, fs[i]);
            ec = q_ctl.pop_front();
            ei = q_ill.pop_front();
            total++;
            if (ctl !== ec || ill !== ei || ill !== 1'b1) begin
                bad++;
                $display("FAIL illegal_f%0d: got ctl=%b ill=%b want ctl=%b ill=%b", fs[i], ctl, ill, ec, ei);
            end
        end
    endtask

    task automatic test_classes();
        logic [5:0] vec [7];
        logic [2:0] ec;
        logic       ei;
        vec = '{{2'b01, 4'd2}, {2'b10, 4'd2}, {2'b10, 4'd15},
                {2'b11, 4'd1}, {2'b11, 4'd0}, {2'b11, 4'd6}, {2'b11, 4'd15}};
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, vec[i][5:4], vec[i][3:0]);
            ec = q_ctl.pop_front();
            ei = q_ill.pop_front();
            total++;
            if (ctl !== ec || ill !== ei) begin
                bad++;
                $display("FAIL class_op%b_f%0d: got ctl=%b ill=%b want ctl=%b ill=%b",
                         vec[i][5:4], vec[i][3:0], ctl, ill, ec, ei);
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0] ec;
        logic       ei;
        apply(1'b1, 2'b00, 4'd5);
        ec = q_ctl.pop_front();
        ei = q_ill.pop_front();
        // Change inputs between edges: outputs must not move yet.
        aluop = 2'b11;
        func  = 4'd2;
        #2;
        total++;
        if (ctl !== ec || ill !== ei) begin
            bad++;
            $display("FAIL hold_midcycle: got ctl=%b ill=%b want ctl=%b ill=%b", ctl, ill, ec, ei);
        end
        @(posedge clk);
        #1;
        total++;
        if (ctl !== 3'b100 || ill !== 1'b0) begin
            bad++;
            $display("FAIL hold_update: got ctl=%b ill=%b want ctl=100 ill=0", ctl, ill);
        end
        @(posedge clk);
        #1;
        total++;
        if (ctl !== 3'b100 || ill !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable: got ctl=%b ill=%b want ctl=100 ill=0", ctl, ill);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ec;
        logic       ei;
        logic [1:0] op;
        logic [3:0] f;
        logic       r;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = 4'($urandom_range(0, 15));
            r  = (i % 13 == 7) ? 1'b0 : 1'b1;
            apply(r, op, f);
            ec = q_ctl.pop_front();
            ei = q_ill.pop_front();
            total++;
            if (ctl !== ec || ill !== ei) begin
                bad++;
                $display("FAIL b2b_%0d rst=%b op=%b f=%0d: got ctl=%b ill=%b want ctl=%b ill=%b",
                         i, r, op, f, ctl, ill, ec, ei);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        aluop = 2'b00;
        func  = 4'd1;
        test_reset();
        test_rtype();
        test_illegal();
        test_classes();
        test_hold();
        test_back_to_back();
        total++;
        if (q_ctl.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q_ctl.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
